ssd1306_spi_driver: RTL

- Display-side end of the row/col/place/data pixel interface used by the game logic.
- Resets and initialises an SSD1306 128x64 OLED over 4-wire SPI (mode 0), then streams frames continuously.
- Drives the row/col/place scan counters and the dc line into the game logic, and serialises the returned data byte MSB-first onto mosi.

---
 rtl/ssd1306_spi_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_driver.sv
// ssd1306_spi_driver
// Resets and initialises an SSD1306 128x64 OLED over 4-wire SPI (mode 0).
// After initialisation it streams pixel bytes continuously. The bytes are
// produced by external game logic from the row/col scan counters.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   data      pixel byte for the current row/col (combinational in row/col)
//   row       current page 0..7
//   col       current column 0..127
//   place     index of the bit currently on mosi (0 = data[7] ... 7 = data[0])
//   dc        0 = command byte, 1 = display data byte
//   sclk      SPI clock, idle low
//   mosi      SPI data, MSB first
//   cs_n      SPI chip select, active low
//   res_n     panel reset, active low
//   streaming high while pixel data is being streamed
module ssd1306_spi_driver #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  output logic [2:0] row,
  output logic [6:0] col,
  output logic [2:0] place,
  output logic       dc,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       res_n,
  output logic       streaming
);

  localparam int DW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [4:0]    ROM_LAST = 5'd30;

  localparam logic [1:0] ST_RST_LOW  = 2'd0;
  localparam logic [1:0] ST_RST_WAIT = 2'd1;
  localparam logic [1:0] ST_INIT     = 2'd2;
  localparam logic [1:0] ST_STREAM   = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] rst_cnt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [2:0]    bit_cnt;
  logic [4:0]    rom_idx;
  logic [7:0]    byte_reg;
  logic [7:0]    rom_cur;

  function automatic logic [7:0] rom_byte(input logic [4:0] idx);
    case (idx)
      5'd0:  rom_byte = 8'hAE;  5'd1:  rom_byte = 8'hD5;
      5'd2:  rom_byte = 8'h80;  5'd3:  rom_byte = 8'hA8;
      5'd4:  rom_byte = 8'h3F;  5'd5:  rom_byte = 8'hD3;
      5'd6:  rom_byte = 8'h00;  5'd7:  rom_byte = 8'h40;
      5'd8:  rom_byte = 8'h8D;  5'd9:  rom_byte = 8'h14;
      5'd10: rom_byte = 8'h20;  5'd11: rom_byte = 8'h00;
      5'd12: rom_byte = 8'hA1;  5'd13: rom_byte = 8'hC8;
      5'd14: rom_byte = 8'hDA;  5'd15: rom_byte = 8'h12;
      5'd16: rom_byte = 8'h81;  5'd17: rom_byte = 8'hCF;
      5'd18: rom_byte = 8'hD9;  5'd19: rom_byte = 8'hF1;
      5'd20: rom_byte = 8'hDB;  5'd21: rom_byte = 8'h40;
      5'd22: rom_byte = 8'hA4;  5'd23: rom_byte = 8'hA6;
      5'd24: rom_byte = 8'h21;  5'd25: rom_byte = 8'h00;
      5'd26: rom_byte = 8'h7F;  5'd27: rom_byte = 8'h22;
      5'd28: rom_byte = 8'h00;  5'd29: rom_byte = 8'h07;
      5'd30: rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  assign rom_cur = rom_byte(rom_idx);
  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  // The bit counter also paces INIT bytes, but the panel-facing place only
  // reflects it while streaming.
  assign place   = streaming ? bit_cnt : 3'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RST_LOW;
      rst_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rom_idx   <= '0;
      byte_reg  <= '0;
      row       <= '0;
      col       <= '0;
      dc        <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      res_n     <= 1'b0;
      streaming <= 1'b0;
    end else begin
      case (state)
        // Panel held in reset
        ST_RST_LOW: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            res_n   <= 1'b1;
            state   <= ST_RST_WAIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        // Panel out of reset, settling before the first command
        ST_RST_WAIT: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            cs_n    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rom_idx <= '0;
            sclk    <= 1'b0;
            state   <= ST_INIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        // Command ROM and pixel streaming share the same bit timing
        ST_INIT, ST_STREAM: begin
          div_cnt <= div_nxt;
          sclk    <= (div_nxt >= DIV_HALF);
          if (div_cnt == '0) begin
            if (state == ST_STREAM) begin
              // data is only trusted on the first clk of a byte
              if (bit_cnt == 3'd0) begin
                byte_reg <= data;
                mosi     <= data[7];
              end else begin
                mosi <= byte_reg[3'd7 - bit_cnt];
              end
            end else begin
              mosi <= rom_cur[3'd7 - bit_cnt];
            end
          end
          if (div_cnt == DIV_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (state == ST_STREAM) begin
              if (bit_cnt == 3'd7) begin
                col <= col + 1'b1;
                if (col == 7'd127) row <= row + 1'b1;
              end
            end else if (bit_cnt == 3'd7) begin
              if (rom_idx == ROM_LAST) begin
                rom_idx   <= '0;
                dc        <= 1'b1;
                streaming <= 1'b1;
                state     <= ST_STREAM;
              end else begin
                rom_idx <= rom_idx + 1'b1;
              end
            end
          end
        end
        default: state <= ST_RST_LOW;
      endcase
    end
  end

endmodule
